axil_reg_bridge: RTL and testbench

AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

---
 rtl/axil_reg_bridge.sv | 182 ++++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to simple register-strobe bridge with independent read/write FSMs.
// Optional out-of-range SLVERR decode enabled by defining AXIL_SLVERR_EN.
`timescale 1ns/1ps
module axil_reg_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_REG_COUNT        = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   reg_awaddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] reg_wstrb,
  output logic                            reg_wren,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   reg_araddr,
  output logic                            reg_rden,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   reg_rdata
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;

`ifdef AXIL_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic [1:0] {
    R_IDLE, R_STROBE, R_CAPTURE, R_RESP
  } rstate_t;

  function automatic logic out_of_range(
    input logic [AW-1:0] a
  );
    return SLVERR_EN &&
      (32'(a[AW-1:2]) >= 32'(C_REG_COUNT));
  endfunction

  wstate_t       w_state_q;
  rstate_t       r_state_q;
  logic          awready_q, wready_q;
  logic          bvalid_q,  wren_q;
  logic [1:0]    bresp_q;
  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          arready_q, rden_q;
  logic          rvalid_q,  rerr_q;
  logic [1:0]    rresp_q;
  logic [AW-1:0] araddr_q;
  logic [DW-1:0] rdata_q;
  logic          aw_err, ar_err;

  assign aw_err = out_of_range(S_AXI_AWADDR);
  assign ar_err = out_of_range(S_AXI_ARADDR);

  // Ready is raised one cycle ahead; the accept is the next edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      wren_q    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
              awaddr_q  <= S_AXI_AWADDR;
              wdata_q   <= S_AXI_WDATA;
              wstrb_q   <= S_AXI_WSTRB;
              wren_q    <= !aw_err;
              bvalid_q  <= 1'b1;
              bresp_q   <= aw_err ? 2'b10 : 2'b00;
              w_state_q <= W_RESP;
            end
          end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          wren_q <= 1'b0;
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            w_state_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rden_q    <= 1'b0;
      rerr_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      araddr_q  <= '0;
      rdata_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (arready_q) begin
            arready_q <= 1'b0;
            if (S_AXI_ARVALID) begin
              araddr_q  <= S_AXI_ARADDR;
              rden_q    <= !ar_err;
              rerr_q    <= ar_err;
              r_state_q <= R_STROBE;
            end
          end else if (S_AXI_ARVALID) begin
            arready_q <= 1'b1;
          end
        end
        R_STROBE: begin
          rden_q    <= 1'b0;
          r_state_q <= R_CAPTURE;
        end
        // reg_rdata is valid now, one cycle after the strobe.
        R_CAPTURE: begin
          rdata_q   <= rerr_q ? '0 : reg_rdata;
          rresp_q   <= rerr_q ? 2'b10 : 2'b00;
          rvalid_q  <= 1'b1;
          r_state_q <= R_RESP;
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_awaddr    = awaddr_q;
  assign reg_wdata     = wdata_q;
  assign reg_wstrb     = wstrb_q;
  assign reg_wren      = wren_q;
  assign reg_araddr    = araddr_q;
  assign reg_rden      = rden_q;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed table-driven bench for axil_reg_bridge with a strobe-driven
// register memory model; expectations follow AXIL_SLVERR_EN when defined.
`timescale 1ns/1ps
module tb_axil_reg_bridge;

`ifdef AXIL_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] awaddr, araddr;
  logic        awvalid, wvalid, bready;
  logic        arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid;
  logic        arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [11:0] r_awaddr, r_araddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wren, r_rden;
  logic [31:0] r_rdata;

  always #5 clk = ~clk;

  axil_reg_bridge dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rstn),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .reg_awaddr(r_awaddr),
    .reg_wdata(r_wdata),
    .reg_wstrb(r_wstrb),
    .reg_wren(r_wren),
    .reg_araddr(r_araddr),
    .reg_rden(r_rden),
    .reg_rdata(r_rdata)
  );

  int errors = 0;
  int checks = 0;
  int wren_cnt = 0;
  int rden_cnt = 0;
  logic wren_prev = 1'b0;
  logic rden_prev = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Register block model: data valid only the cycle after reg_rden.
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (r_wren)
      for (int b = 0; b < 4; b++)
        if (r_wstrb[b])
          mem[r_awaddr[11:2]][8*b +: 8] <= r_wdata[8*b +: 8];
    r_rdata <= r_rden ? mem[r_araddr[11:2]] : 32'hBAD0BAD0;
  end

  always @(negedge clk) begin
    if (r_wren) begin
      wren_cnt++;
      chk("wren_one_cycle", {31'b0, wren_prev}, 0);
    end
    if (r_rden) begin
      rden_cnt++;
      chk("rden_one_cycle", {31'b0, rden_prev}, 0);
    end
    wren_prev = r_wren;
    rden_prev = r_rden;
  end

  logic outs_nz;
  assign outs_nz = |{awready, wready, bvalid, bresp,
                     arready, rvalid, rresp, rdata,
                     r_awaddr, r_wdata, r_wstrb, r_wren,
                     r_araddr, r_rden};

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    int          hold;
    logic        strobe;
    logic [1:0]  resp;
    logic [31:0] rdat;
  } vec_t;

  task automatic do_write(input vec_t v);
    int cyc;
    int c0;
    c0 = wren_cnt;
    awaddr = v.addr;
    wdata = v.data;
    wstrb = v.strb;
    awvalid = 1'b1;
    wvalid = (v.lead == 0);
    bready = 1'b0;
    for (int i = 0; i < v.lead; i++) begin
      @(posedge clk); #1;
      chk("aw_alone_awready", {31'b0, awready}, 0);
      chk("aw_alone_wready", {31'b0, wready}, 0);
    end
    wvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("aw_accept", {31'b0, awready}, 1);
    if (!awready) begin
      awvalid = 1'b0;
      wvalid = 1'b0;
      return;
    end
    chk("wready_with_aw", {31'b0, wready}, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    chk("wr_wren", {31'b0, r_wren}, {31'b0, v.strobe});
    chk("wr_bvalid", {31'b0, bvalid}, 1);
    chk("wr_bresp", {30'b0, bresp}, {30'b0, v.resp});
    chk("wr_awaddr", {20'b0, r_awaddr}, {20'b0, v.addr});
    chk("wr_wdata", r_wdata, v.data);
    chk("wr_wstrb", {28'b0, r_wstrb}, {28'b0, v.strb});
    chk("wr_awready_low", {31'b0, awready}, 0);
    for (int i = 1; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk("wr_bvalid_held", {31'b0, bvalid}, 1);
      chk("wr_bresp_held", {30'b0, bresp}, {30'b0, v.resp});
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("wr_bvalid_drop", {31'b0, bvalid}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("wr_no_reaccept", {31'b0, awready}, 0);
    chk("wr_wren_count", wren_cnt - c0, {31'b0, v.strobe});
  endtask

  task automatic do_read(input vec_t v);
    int cyc;
    int c0;
    c0 = rden_cnt;
    araddr = v.addr;
    arvalid = 1'b1;
    rready = 1'b0;
    cyc = 0;
    while (!arready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ar_accept", {31'b0, arready}, 1);
    if (!arready) begin
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rd_rden", {31'b0, r_rden}, {31'b0, v.strobe});
    chk("rd_araddr", {20'b0, r_araddr}, {20'b0, v.addr});
    chk("rd_arready_low", {31'b0, arready}, 0);
    chk("rd_rvalid_early1", {31'b0, rvalid}, 0);
    @(posedge clk); #1;
    chk("rd_rden_off", {31'b0, r_rden}, 0);
    chk("rd_rvalid_early2", {31'b0, rvalid}, 0);
    @(posedge clk); #1;
    chk("rd_rvalid", {31'b0, rvalid}, 1);
    chk("rd_rdata", rdata, v.rdat);
    chk("rd_rresp", {30'b0, rresp}, {30'b0, v.resp});
    for (int i = 1; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk("rd_rvalid_held", {31'b0, rvalid}, 1);
      chk("rd_rdata_stable", rdata, v.rdat);
      chk("rd_rresp_stable", {30'b0, rresp}, {30'b0, v.resp});
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rd_rvalid_drop", {31'b0, rvalid}, 0);
    chk("rd_rden_count", rden_cnt - c0, {31'b0, v.strobe});
    @(posedge clk); #1;
  endtask

  vec_t tbl [9];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b1, 12'h004, 32'h000186A0, 4'hF, 0, 0,
               1'b1, 2'b00, 32'h0};
    tbl[1] = '{1'b0, 12'h004, 32'h0, 4'h0, 0, 0,
               1'b1, 2'b00, 32'h000186A0};
    tbl[2] = '{1'b1, 12'h008, 32'h0000C350, 4'hF, 3, 4,
               1'b1, 2'b00, 32'h0};
    tbl[3] = '{1'b0, 12'h008, 32'h0, 4'h0, 0, 5,
               1'b1, 2'b00, 32'h0000C350};
    tbl[4] = '{1'b1, 12'h00C, 32'hFFFFFFFF, 4'b0101, 0, 2,
               1'b1, 2'b00, 32'h0};
    tbl[5] = '{1'b0, 12'h00C, 32'h0, 4'h0, 0, 0,
               1'b1, 2'b00, 32'h00FF00FF};
    tbl[6] = '{1'b1, 12'h040, 32'h12345678, 4'hF, 0, 0,
               !SLV, SLV ? 2'b10 : 2'b00, 32'h0};
    tbl[7] = '{1'b0, 12'h040, 32'h0, 4'h0, 0, 2,
               !SLV, SLV ? 2'b10 : 2'b00,
               SLV ? 32'h0 : 32'h12345678};
    tbl[8] = '{1'b0, 12'h000, 32'h0, 4'h0, 0, 0,
               1'b1, 2'b00, 32'h0};

    rstn = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_zero", {31'b0, outs_nz}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {31'b0, outs_nz}, 0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].wr) do_write(tbl[i]);
      else do_read(tbl[i]);
    end

    // Concurrent read and write, then reset mid-flight.
    awaddr = 12'h000;
    wdata = 32'hA5A5A5A5;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    araddr = 12'h004;
    arvalid = 1'b1;
    for (int c = 0; c < 20 && !arready; c++) begin
      @(posedge clk); #1;
    end
    chk("cc_arready", {31'b0, arready}, 1);
    chk("cc_awready", {31'b0, awready}, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    arvalid = 1'b0;
    chk("cc_bvalid", {31'b0, bvalid}, 1);
    chk("cc_rden", {31'b0, r_rden}, 1);
    chk("cc_wren", {31'b0, r_wren}, 1);
    @(posedge clk); #1;
    chk("cc_capture_rvalid", {31'b0, rvalid}, 0);
    chk("cc_bvalid_held", {31'b0, bvalid}, 1);
    rstn = 1'b0;
    #1;
    chk("rst_async_zero", {31'b0, outs_nz}, 0);
    @(posedge clk); #1;
    chk("rst_hold_zero", {31'b0, outs_nz}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_zero", {31'b0, outs_nz}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_response", {31'b0, bvalid | rvalid}, 0);
    rv = '{1'b0, 12'h000, 32'h0, 4'h0, 0, 2,
           1'b1, 2'b00, 32'hA5A5A5A5};
    do_read(rv);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
